// File: rtl/branch_resolve_ctrl.sv
// RV32I branch resolution: one branch in flight, comparator, mispredict
// detection with flush/redirect handshake, and saturating statistics.
module branch_resolve_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_funct3,
    input  logic [DWIDTH-1:0] br_rs1,
    input  logic [DWIDTH-1:0] br_rs2,
    input  logic [AWIDTH-1:0] br_pc,
    input  logic [AWIDTH-1:0] br_imm,
    input  logic              br_pred_taken,
    input  logic              kill,
    output logic              resolved_valid,
    output logic              resolved_taken,
    output logic              flush,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [AWIDTH-1:0] redirect_pc,
    output logic              illegal,
    output logic              misalign,
    input  logic              stat_clr,
    output logic [CNTW-1:0]   stat_branches,
    output logic [CNTW-1:0]   stat_mispredicts
);

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

    state_t state_q, state_d;

    logic [2:0]        f3_q;
    logic [DWIDTH-1:0] rs1_q, rs2_q;
    logic [AWIDTH-1:0] pc_q, imm_q;
    logic              pred_q;

    logic resolved_q, resolved_d;
    logic taken_q, taken_d;
    logic flush_q, flush_d;
    logic illegal_q, illegal_d;
    logic misalign_q, misalign_d;
    logic rv_q, rv_d;
    logic [AWIDTH-1:0] rpc_q, rpc_d;
    logic [CNTW-1:0] cnt_br_q, cnt_br_d;
    logic [CNTW-1:0] cnt_mp_q, cnt_mp_d;
    logic br_inc, mp_inc;

    logic hs;
    logic br_un, br_eq, br_lt, taken, legal;
    logic [AWIDTH-1:0] target, fallthru;

    assign br_ready = (state_q == IDLE) && !kill && !rst;
    assign hs       = br_valid && br_ready;

    assign br_un = f3_q[1];
    assign br_eq = (rs1_q == rs2_q);
    assign br_lt = br_un ? (rs1_q < rs2_q)
                         : ($signed(rs1_q) < $signed(rs2_q));
    assign legal    = (f3_q[2:1] != 2'b01);
    assign target   = pc_q + imm_q;
    assign fallthru = pc_q + AWIDTH'(4);

    always_comb begin
        taken = 1'b0;
        unique case (f3_q)
            3'b000:  taken = br_eq;
            3'b001:  taken = !br_eq;
            3'b100:  taken = br_lt;
            3'b101:  taken = !br_lt;
            3'b110:  taken = br_lt;
            3'b111:  taken = !br_lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        resolved_d = 1'b0;
        taken_d    = 1'b0;
        flush_d    = 1'b0;
        illegal_d  = 1'b0;
        misalign_d = 1'b0;
        rv_d       = rv_q;
        rpc_d      = rpc_q;
        br_inc     = 1'b0;
        mp_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs) state_d = EVAL;
            end
            EVAL: begin
                state_d = IDLE;
                if (kill) begin
                    state_d = IDLE;
                end else if (!legal) begin
                    illegal_d = 1'b1;
                end else begin
                    resolved_d = 1'b1;
                    taken_d    = taken;
                    br_inc     = 1'b1;
                    if (taken && target[1]) begin
                        misalign_d = 1'b1;
                    end else if (taken != pred_q) begin
                        flush_d = 1'b1;
                        mp_inc  = 1'b1;
                        rv_d    = 1'b1;
                        rpc_d   = taken ? target : fallthru;
                        state_d = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                // kill and acceptance both retire the redirect
                if (kill || redirect_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_br_d = cnt_br_q;
        cnt_mp_d = cnt_mp_q;
        if (stat_clr) begin
            cnt_br_d = '0;
            cnt_mp_d = '0;
        end else begin
            if (br_inc && cnt_br_q != '1) cnt_br_d = cnt_br_q + CNTW'(1);
            if (mp_inc && cnt_mp_q != '1) cnt_mp_d = cnt_mp_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            f3_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            pred_q     <= 1'b0;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            flush_q    <= 1'b0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            cnt_br_q   <= '0;
            cnt_mp_q   <= '0;
        end else begin
            state_q    <= state_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            flush_q    <= flush_d;
            illegal_q  <= illegal_d;
            misalign_q <= misalign_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            cnt_br_q   <= cnt_br_d;
            cnt_mp_q   <= cnt_mp_d;
            if (hs) begin
                f3_q   <= br_funct3;
                rs1_q  <= br_rs1;
                rs2_q  <= br_rs2;
                pc_q   <= br_pc;
                imm_q  <= br_imm;
                pred_q <= br_pred_taken;
            end
        end
    end

    assign resolved_valid   = resolved_q;
    assign resolved_taken   = taken_q;
    assign flush            = flush_q;
    assign illegal          = illegal_q;
    assign misalign         = misalign_q;
    assign redirect_valid   = rv_q;
    assign redirect_pc      = rpc_q;
    assign stat_branches    = cnt_br_q;
    assign stat_mispredicts = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table plus corner sequences.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [2:0]  br_funct3 = '0;
    logic [31:0] br_rs1 = '0, br_rs2 = '0, br_pc = '0, br_imm = '0;
    logic        br_pred_taken = 1'b0;
    logic        kill = 1'b0;
    logic        redirect_ready = 1'b1;
    logic        stat_clr = 1'b0;

    logic        br_ready, resolved_valid, resolved_taken, flush;
    logic        redirect_valid, illegal, misalign;
    logic [31:0] redirect_pc;
    logic [15:0] stat_branches, stat_mispredicts;

    logic        s_ready, s_res, s_tkn, s_flush, s_rv, s_ill, s_mis;
    logic [31:0] s_rpc;
    logic [1:0]  s_br, s_mp;

    int checks = 0;
    int failures = 0;
    int exp_br = 0, exp_mp = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.DWIDTH(32), .AWIDTH(32), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .br_funct3(br_funct3), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .br_pc(br_pc), .br_imm(br_imm), .br_pred_taken(br_pred_taken),
        .kill(kill), .resolved_valid(resolved_valid),
        .resolved_taken(resolved_taken), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .illegal(illegal), .misalign(misalign),
        .stat_clr(stat_clr), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    branch_resolve_ctrl #(.DWIDTH(32), .AWIDTH(32), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(s_ready),
        .br_funct3(br_funct3), .br_rs1(br_rs1), .br_rs2(br_rs2),
        .br_pc(br_pc), .br_imm(br_imm), .br_pred_taken(br_pred_taken),
        .kill(kill), .resolved_valid(s_res),
        .resolved_taken(s_tkn), .flush(s_flush),
        .redirect_valid(s_rv), .redirect_ready(redirect_ready),
        .redirect_pc(s_rpc), .illegal(s_ill), .misalign(s_mis),
        .stat_clr(stat_clr), .stat_branches(s_br),
        .stat_mispredicts(s_mp)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred;
        logic        res, tkn, fl, ill, mis, rv;
        logic [31:0] rpc;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk_cnt(input string tag);
        chk({tag, " stat_branches"}, 32'(stat_branches), exp_br);
        chk({tag, " stat_mispredicts"}, 32'(stat_mispredicts), exp_mp);
        chk({tag, " sat stat_branches"}, 32'(s_br), sat3(exp_br));
        chk({tag, " sat stat_mispredicts"}, 32'(s_mp), sat3(exp_mp));
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred);
        br_valid = 1'b1;
        br_funct3 = f3;
        br_rs1 = rs1;
        br_rs2 = rs2;
        br_pc = pc;
        br_imm = imm;
        br_pred_taken = pred;
    endtask

    // Handshake in the current cycle N; returns at N+2.
    task automatic issue(input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred);
        drive(f3, rs1, rs2, pc, imm, pred);
        step();
        br_valid = 1'b0;
        step();
    endtask

    initial begin
        vecs[0]  = '{3'b000, 5, 5, 32'h100, 32'h20, 0, 1, 1, 1, 0, 0, 1, 32'h120};
        vecs[1]  = '{3'b100, 32'hFFFFFFFF, 1, 32'h200, 32'h40, 0,
                     1, 1, 1, 0, 0, 1, 32'h240};
        vecs[2]  = '{3'b110, 32'hFFFFFFFF, 1, 32'h200, 32'h40, 0,
                     1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{3'b001, 3, 3, 32'h300, 32'h10, 1, 1, 0, 1, 0, 0, 1, 32'h304};
        vecs[4]  = '{3'b101, 32'h80000000, 0, 32'h400, 32'h8, 0,
                     1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{3'b111, 32'h80000000, 0, 32'h400, 32'h8, 1,
                     1, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{3'b010, 1, 1, 32'h100, 32'h20, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{3'b011, 1, 2, 32'h100, 32'h20, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{3'b000, 1, 1, 32'h100, 32'h6, 0, 1, 1, 0, 0, 1, 0, 0};
        vecs[9]  = '{3'b001, 1, 2, 32'hFFFFFFFC, 32'h8, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{3'b000, 1, 2, 32'hFFFFFFFC, 32'h8, 1, 1, 0, 1, 0, 0, 1, 0};
        vecs[11] = '{3'b101, 7, 7, 32'h500, 32'hFFFFFFF0, 0,
                     1, 1, 1, 0, 0, 1, 32'h4F0};
        vecs[12] = '{3'b001, 1, 1, 32'h100, 32'h6, 0, 1, 0, 0, 0, 0, 0, 0};

        // reset state
        #2;
        chk("rst br_ready", 32'(br_ready), 0);
        chk("rst resolved_valid", 32'(resolved_valid), 0);
        chk("rst redirect_valid", 32'(redirect_valid), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk_cnt("rst");
        step();
        rst = 1'b0;
        #1;
        chk("post-rst br_ready", 32'(br_ready), 1);

        // vector table
        for (int i = 0; i < 13; i++) begin
            redirect_ready = 1'b1;
            issue(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc,
                  vecs[i].imm, vecs[i].pred);
            if (vecs[i].res) exp_br++;
            if (vecs[i].fl) exp_mp++;
            chk($sformatf("v%0d resolved_valid", i), 32'(resolved_valid), 32'(vecs[i].res));
            chk($sformatf("v%0d resolved_taken", i), 32'(resolved_taken), 32'(vecs[i].tkn));
            chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].fl));
            chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
            chk($sformatf("v%0d misalign", i), 32'(misalign), 32'(vecs[i].mis));
            chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].rv));
            if (vecs[i].rv)
                chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
            else
                chk($sformatf("v%0d br_ready N+2", i), 32'(br_ready), 1);
            chk_cnt($sformatf("v%0d", i));
            step();
            chk($sformatf("v%0d pulse end", i),
                32'({resolved_valid, flush, illegal, misalign, redirect_valid}), 0);
            chk($sformatf("v%0d br_ready N+3", i), 32'(br_ready), 1);
        end

        // redirect held while fetch stalls
        redirect_ready = 1'b0;
        issue(3'b001, 1, 2, 32'h600, 32'h20, 0);
        exp_br++;
        exp_mp++;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall%0d redirect_valid", i), 32'(redirect_valid), 1);
            chk($sformatf("stall%0d redirect_pc", i), redirect_pc, 32'h620);
            chk($sformatf("stall%0d br_ready", i), 32'(br_ready), 0);
            if (i == 3) redirect_ready = 1'b1;
            step();
        end
        chk("stall drop redirect_valid", 32'(redirect_valid), 0);
        chk("stall drop br_ready", 32'(br_ready), 1);
        chk_cnt("stall");

        // kill in REDIRECT
        redirect_ready = 1'b0;
        issue(3'b000, 5, 5, 32'h100, 32'h20, 0);
        exp_br++;
        exp_mp++;
        kill = 1'b1;
        #1;
        chk("kill-redir br_ready", 32'(br_ready), 0);
        step();
        kill = 1'b0;
        #1;
        chk("kill-redir redirect_valid", 32'(redirect_valid), 0);
        chk("kill-redir br_ready", 32'(br_ready), 1);
        redirect_ready = 1'b1;

        // kill with br_valid in IDLE: nothing captured
        kill = 1'b1;
        drive(3'b000, 5, 5, 32'h100, 32'h20, 0);
        #1;
        chk("kill-idle br_ready", 32'(br_ready), 0);
        step();
        br_valid = 1'b0;
        kill = 1'b0;
        step();
        chk("kill-idle resolved_valid", 32'(resolved_valid), 0);
        chk("kill-idle flush", 32'(flush), 0);
        chk_cnt("kill-idle");

        // kill in EVAL
        drive(3'b000, 5, 5, 32'h100, 32'h20, 0);
        step();
        br_valid = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        #1;
        chk("kill-eval pulses",
            32'({resolved_valid, flush, redirect_valid}), 0);
        chk("kill-eval br_ready", 32'(br_ready), 1);
        chk_cnt("kill-eval");

        // saturation
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        chk_cnt("clr");
        for (int i = 0; i < 5; i++) begin
            issue(3'b000, 5, 5, 32'h100, 32'h20, 0);
            exp_br++;
            exp_mp++;
            step();
        end
        chk_cnt("sat");
        chk("sat small branches", 32'(s_br), 3);

        // clear coincident with a resolve
        drive(3'b000, 5, 5, 32'h100, 32'h20, 1);
        step();
        br_valid = 1'b0;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        chk("clr+res resolved_valid", 32'(resolved_valid), 1);
        chk_cnt("clr+res");
        step();

        // reset during EVAL
        issue(3'b000, 5, 5, 32'h100, 32'h20, 0);
        step();
        drive(3'b001, 1, 2, 32'h700, 32'h20, 0);
        step();
        br_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst-eval outputs",
            32'({resolved_valid, resolved_taken, flush, redirect_valid,
                 illegal, misalign, br_ready}), 0);
        chk("rst-eval redirect_pc", redirect_pc, 0);
        exp_br = 0;
        exp_mp = 0;
        chk_cnt("rst-eval");
        step();
        rst = 1'b0;
        #1;
        chk("rst-eval br_ready", 32'(br_ready), 1);
        step();
        chk("rst-eval no resolve", 32'({resolved_valid, flush}), 0);
        chk_cnt("rst-eval after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Branch resolution controller for the RV32I execute stage. It accepts one conditional branch at a time from decode over a valid/ready handshake and decodes funct3 into the comparator controls (unsigned select, equal, less-than). It drives an internal equality/less-than comparator, decides taken/not-taken and checks the decision against the front-end prediction. On a mispredict it pulses a pipeline flush and holds a redirect PC until fetch accepts it. It also keeps saturating branch and mispredict counters.

## Interface

- DWIDTH, 32, operand width
- AWIDTH, 32, PC/address width
- CNTW, 16, statistics counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- br_valid  in  1  branch request valid
- br_ready  out  1  controller can accept a request
- br_funct3  in  3  RV32I branch funct3
- br_rs1, br_rs2  in  DWIDTH  operands
- br_pc  in  AWIDTH  PC of the branch
- br_imm  in  AWIDTH  sign-extended branch offset
- br_pred_taken  in  1  front-end prediction
- kill  in  1  upstream squash of in-flight branch
- resolved_valid  out  1  one-cycle pulse: legal branch resolved
- resolved_taken  out  1  outcome, valid with resolved_valid
- flush  out  1  one-cycle pulse on mispredict
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts redirect
- redirect_pc  out  AWIDTH  corrected fetch PC
- illegal  out  1  one-cycle pulse: funct3 010/011
- misalign  out  1  one-cycle pulse: taken target with bit 1 set
- stat_clr  in  1  synchronous counter clear
- stat_branches, stat_mispredicts  out  CNTW  saturating counters

## Operation

- States: IDLE, EVAL, REDIRECT.
- br_ready = (state==IDLE) && !kill, combinational. Handshake = br_valid && br_ready.
- IDLE: on handshake, register funct3, rs1, rs2, pc, imm, pred_taken; go to EVAL.
- EVAL: the comparator operates on the registered operands.
  - BrUn = funct3[1]. BrEq = rs1==rs2. BrLt is signed compare when BrUn=0, unsigned when BrUn=1.
  - taken by funct3: 000 BEQ = eq; 001 BNE = !eq; 100 BLT = lt; 101 BGE = !lt; 110 BLTU = lt; 111 BGEU = !lt.
  - funct3 010/011: illegal pulse; no resolved pulse; no counter change; go to IDLE.
  - target = pc+imm mod 2^AWIDTH. fallthrough = pc+4 mod 2^AWIDTH.
  - taken && target[1]: misalign pulse; resolved pulse; stat_branches incremented; no mispredict, flush or redirect; go to IDLE.
  - Otherwise: resolved pulse and stat_branches incremented.
    - If taken != pred_taken: flush pulse, stat_mispredicts incremented, redirect_valid=1, redirect_pc = taken ? target : fallthrough; go to REDIRECT.
    - Else go to IDLE.
- REDIRECT: redirect_valid and redirect_pc held stable until redirect_valid && redirect_ready. Then go to IDLE; redirect_valid is 0 the following cycle.
- kill, in EVAL or REDIRECT: go to IDLE next cycle. No pulses, no counter updates, redirect_valid drops. kill has priority over all other events in that cycle.
- Counters:
  - Each saturates at all-ones.
  - stat_clr zeroes both.
  - stat_clr and an increment in the same cycle: clear wins.

## Timing

- Reset values: state IDLE; all pulses, redirect_valid, resolved_taken, redirect_pc and counters 0. br_ready is 0 while rst is high and 1 in the first cycle after release if kill=0.
- Handshake in cycle N: EVAL in N+1. resolved_valid, resolved_taken, flush, illegal and misalign are registered and visible in N+2 for exactly one cycle. redirect_valid rises in N+2.
- No mispredict: br_ready=1 again in N+2, so peak throughput is one branch per 2 cycles.
- redirect_ready already high in N+2: redirect_valid is 1 for exactly one cycle; IDLE in N+3.
- Counter values update in the same cycle as the corresponding pulse.
- rst asserted mid-operation: immediate return to the reset values; the in-flight branch is discarded.

## Test plan

- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> N+2: resolved_taken=1, flush=1, redirect_pc=0x120; stat_branches=1, stat_mispredicts=1.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1, pred=0 -> BLT taken (mispredict, redirect to target); BLTU not taken (no flush, br_ready=1 at N+2).
- Mispredicted BNE with redirect_ready held low 3 cycles -> redirect_valid and redirect_pc stable 3 cycles; drop 1 cycle after ready; br_ready=0 throughout.
- funct3=010 -> illegal pulse at N+2, no resolved pulse, counters unchanged. Taken BEQ with imm=0x6 -> misalign pulse, no redirect.
- kill asserted in REDIRECT -> IDLE next cycle, redirect_valid=0; kill with br_valid in IDLE -> no capture.
- CNTW=2, 5 mispredicts -> both counters stick at 3; stat_clr coincident with a resolve -> both counters 0. rst pulse during EVAL -> all outputs 0, no resolved pulse.
